// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the IF and MEM pipeline ports.
// Ports: clk/rst; flush_i; IF req/addr/rdata/ack; MEM req/we/be/addr/wdata/rdata/ack;
//        bus req/we/be/addr/wdata (registered), bus rdata/ack; stall requests per port.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ack_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [DATA_W/8-1:0] mem_be_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_ack_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_be_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic                stallreq_if_o,
    output logic                stallreq_mem_o
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_IF_BUSY,
        S_MEM_BUSY,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                last_mem_q, last_mem_d;
    logic                drop_if_q, drop_if_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [BE_W-1:0]     bus_be_q, bus_be_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                mem_ack_q, mem_ack_d;

    logic                if_ok;
    logic                grant_mem;
    logic                grant_if;

    // A flush withdraws IF from arbitration; MEM then wins even if it
    // had the bus last, since it is the only eligible port.
    assign if_ok     = if_req_i & ~flush_i;
    assign grant_mem = mem_req_i & (~if_ok | ~last_mem_q);
    assign grant_if  = if_ok & ~grant_mem;

    always_comb begin
        state_d     = state_q;
        last_mem_d  = last_mem_q;
        drop_if_d   = drop_if_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_mem) begin
                    state_d     = S_MEM_BUSY;
                    last_mem_d  = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_be_d    = mem_be_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                end else if (grant_if) begin
                    state_d     = S_IF_BUSY;
                    last_mem_d  = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = '0;
                end
            end
            S_IF_BUSY: begin
                if (flush_i) begin
                    drop_if_d = 1'b1;
                end
                if (bus_ack_i) begin
                    // A flush in the ack cycle itself also kills delivery.
                    if_rdata_d = bus_rdata_i;
                    if_ack_d   = ~(drop_if_q | flush_i);
                    bus_req_d  = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_MEM_BUSY: begin
                if (bus_ack_i) begin
                    mem_rdata_d = bus_rdata_i;
                    mem_ack_d   = 1'b1;
                    bus_req_d   = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                drop_if_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_mem_q  <= 1'b0;
            drop_if_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_mem_q  <= last_mem_d;
            drop_if_q   <= drop_if_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
        end
    end

    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_be_o       = bus_be_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign if_rdata_o     = if_rdata_q;
    assign mem_rdata_o    = mem_rdata_q;
    assign if_ack_o       = if_ack_q;
    assign mem_ack_o      = mem_ack_q;

    // Registered acks make the stall drop exactly in the ack cycle.
    assign stallreq_if_o  = ~rst & if_req_i & ~if_ack_q;
    assign stallreq_mem_o = ~rst & mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus with a scoreboard of expected acks
// and a simple memory model with configurable wait states.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_be_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    bit   auto_mem = 1'b1;
    int   mem_wait = 2;
    int   wcnt = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], 16'hC0DE};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_if, input logic [31:0] d);
        exp_t e;
        e.is_if = is_if;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit is_if, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (is_if ? if_ack_o : mem_ack_o) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: ack timeout got 0 expected 1", nm);
        end
        step();
    endtask

    // Memory model: acks after mem_wait cycles of bus_req_o.
    initial begin
        forever begin
            step();
            if (auto_mem) begin
                if (bus_req_o && !bus_ack_i && !rst) begin
                    if (wcnt == mem_wait) begin
                        bus_ack_i   = 1'b1;
                        bus_rdata_i = mem_f(bus_addr_o);
                        wcnt        = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    bus_ack_i = 1'b0;
                    if (!bus_req_o) wcnt = 0;
                end
            end
        end
    end

    // Monitor: every delivered ack must match the oldest expectation.
    always @(negedge clk) begin
        if (if_ack_o || mem_ack_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got ack if=%0d mem=%0d expected none",
                         if_ack_o, mem_ack_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_port_is_if", {31'b0, if_ack_o}, {31'b0, e.is_if});
                chk("sb_rdata", if_ack_o ? if_rdata_o : mem_rdata_o, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;

        // Reset state, stall forced low while rst is high.
        rst = 1'b1;
        if_req_i = 1'b1;
        mem_req_i = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("rst_stall_if", {31'b0, stallreq_if_o}, 32'd0);
        chk("rst_stall_mem", {31'b0, stallreq_mem_o}, 32'd0);
        chk("rst_bus_req", {31'b0, bus_req_o}, 32'd0);
        chk("rst_bus_be", {28'b0, bus_be_o}, 32'd0);
        chk("rst_if_ack", {31'b0, if_ack_o}, 32'd0);
        chk("rst_mem_rdata", mem_rdata_o, 32'd0);
        step();
        if_req_i = 1'b0;
        mem_req_i = 1'b0;
        rst = 1'b0;
        repeat (2) step();

        // IF only, memory waits 2 cycles.
        mem_wait = 2;
        if_req_i = 1'b1;
        if_addr_i = 32'h100;
        push(1'b1, 32'hDEADBEEF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t1_bus_req_c%0d", c), {31'b0, bus_req_o},
                {31'b0, (c >= 1 && c <= 3)});
            chk($sformatf("t1_stall_if_c%0d", c), {31'b0, stallreq_if_o},
                {31'b0, (c <= 3)});
            if (c == 1) begin
                chk("t1_bus_addr", bus_addr_o, 32'h100);
                chk("t1_bus_we", {31'b0, bus_we_o}, 32'd0);
                chk("t1_bus_be", {28'b0, bus_be_o}, 32'hF);
            end
            if (c == 4) chk("t1_if_ack", {31'b0, if_ack_o}, 32'd1);
            step();
        end
        if_req_i = 1'b0;
        repeat (2) step();

        // Both ports, zero-wait memory: MEM, IF, MEM, IF.
        mem_wait = 0;
        if_addr_i = 32'h200;
        mem_we_i = 1'b0;
        mem_be_i = 4'hF;
        mem_addr_i = 32'h3000;
        if_req_i = 1'b1;
        mem_req_i = 1'b1;
        push(1'b0, 32'h3000C0DE);
        push(1'b1, 32'h0200C0DE);
        push(1'b0, 32'h3000C0DE);
        push(1'b1, 32'h0200C0DE);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("t2_stall_mem_c%0d", c), {31'b0, stallreq_mem_o},
                {31'b0, !(c == 2 || c == 8)});
            chk($sformatf("t2_stall_if_c%0d", c), {31'b0, stallreq_if_o},
                {31'b0, !(c == 5 || c == 11)});
            if (c == 1) chk("t2_addr_mem", bus_addr_o, 32'h3000);
            if (c == 4) chk("t2_addr_if", bus_addr_o, 32'h200);
            step();
        end
        if_req_i = 1'b0;
        mem_req_i = 1'b0;
        repeat (2) step();

        // Store with partial byte enables, memory waits 1 cycle.
        mem_wait = 1;
        mem_req_i = 1'b1;
        mem_we_i = 1'b1;
        mem_be_i = 4'b0011;
        mem_addr_i = 32'h2004;
        mem_wdata_i = 32'h00001234;
        push(1'b0, 32'h2004C0DE);
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_ack_o) acks++;
            if (c == 1 || c == 2) begin
                chk($sformatf("t3_we_c%0d", c), {31'b0, bus_we_o}, 32'd1);
                chk($sformatf("t3_be_c%0d", c), {28'b0, bus_be_o}, 32'h3);
                chk($sformatf("t3_wdata_c%0d", c), bus_wdata_o, 32'h1234);
                chk($sformatf("t3_addr_c%0d", c), bus_addr_o, 32'h2004);
            end
            step();
            if (c == 3) mem_req_i = 1'b0;
        end
        chk("t3_mem_ack_pulses", acks, 32'd1);
        mem_we_i = 1'b0;
        repeat (2) step();

        // Flush while IF_BUSY: first result dropped, next one served.
        mem_wait = 2;
        if_req_i = 1'b1;
        if_addr_i = 32'h400;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (if_ack_o) acks++;
            step();
            flush_i = (c == 1);
            if (c == 2) begin
                if_addr_i = 32'h500;
                push(1'b1, 32'h0500C0DE);
            end
        end
        chk("t4_if_ack_suppressed", acks, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("t4_regrant_req", {31'b0, bus_req_o}, 32'd1);
        chk("t4_regrant_addr", bus_addr_o, 32'h500);
        wait_ack(1'b1, "t4_next_if");
        if_req_i = 1'b0;
        repeat (2) step();

        // Reset during MEM_BUSY, then a stray bus ack.
        auto_mem = 1'b0;
        bus_ack_i = 1'b0;
        mem_req_i = 1'b1;
        mem_addr_i = 32'h6000;
        step();
        @(negedge clk);
        chk("t5_busy_req", {31'b0, bus_req_o}, 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_stall_mem", {31'b0, stallreq_mem_o}, 32'd0);
        step();
        rst = 1'b0;
        mem_req_i = 1'b0;
        @(negedge clk);
        chk("t5_bus_req", {31'b0, bus_req_o}, 32'd0);
        chk("t5_bus_addr", bus_addr_o, 32'd0);
        chk("t5_bus_wdata", bus_wdata_o, 32'd0);
        chk("t5_bus_we_be", {27'b0, bus_we_o, bus_be_o}, 32'd0);
        chk("t5_if_rdata", if_rdata_o, 32'd0);
        chk("t5_acks", {30'b0, if_ack_o, mem_ack_o}, 32'd0);
        step();
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hBAD0BAD0;
        step();
        bus_ack_i = 1'b0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_ack_o) acks++;
            step();
        end
        chk("t5_stray_no_ack", acks, 32'd0);
        chk("t5_mem_rdata", mem_rdata_o, 32'd0);
        auto_mem = 1'b1;
        mem_wait = 1;
        if_req_i = 1'b1;
        if_addr_i = 32'h700;
        push(1'b1, 32'h0700C0DE);
        wait_ack(1'b1, "t5_if_after_rst");
        if_req_i = 1'b0;
        repeat (3) step();

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
